// File: rtl/pim_model.sv
// pim_model: word-addressed single-port memory with a built-in multiply-accumulate engine.
//
// Each cycle the caller issues at most one of: write (w_en), combinational read (q), or
// compute (p_en). Compute multiplies the low and high halves of the addressed word and adds
// the product into the mac_out accumulator.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset, clears mac_out only (memory is kept)
//   q       - combinational read data for addr (zero when addr is out of range)
//   mac_out - registered MAC accumulator
//   d       - write data
//   addr    - word address shared by read, write and compute
//   w_en    - write enable, also clears the accumulator
//   p_en    - compute enable
module pim_model #(
    parameter int unsigned PIM_ADDR_BEGIN = 0,
    parameter int unsigned DWIDTH         = 32,
    parameter int unsigned AWIDTH         = 16,
    parameter int unsigned PWIDTH         = 32,
    parameter int unsigned PDEPTH         = 1 << AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PWIDTH-1:0] q,
    output logic [DWIDTH-1:0] mac_out,
    input  logic [DWIDTH-1:0] d,
    input  logic [AWIDTH-1:0] addr,
    input  logic              w_en,
    input  logic              p_en
);

    localparam int unsigned HW = DWIDTH / 2;
    localparam int unsigned IW = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;

    // Zero at time zero; reset deliberately leaves the contents alone.
    logic [DWIDTH-1:0] mem [PDEPTH] = '{default: '0};

    logic [63:0]       addr_ext;
    logic [63:0]       offset;
    logic              in_range;
    logic [IW-1:0]     idx;
    logic [DWIDTH-1:0] rd_word;
    logic [HW-1:0]     lo;
    logic [HW-1:0]     hi;
    logic [DWIDTH-1:0] prod;
    logic [DWIDTH-1:0] mac_d;
    logic [DWIDTH-1:0] mac_q;

    // Range check is done at 64 bits so neither the base subtraction nor the depth
    // comparison can wrap for any legal parameter set.
    always_comb begin
        addr_ext = 64'(addr);
        offset   = addr_ext - 64'(PIM_ADDR_BEGIN);
        in_range = (addr_ext >= 64'(PIM_ADDR_BEGIN)) && (offset < 64'(PDEPTH));
        idx      = IW'(offset);
        rd_word  = in_range ? mem[idx] : '0;
    end

    // Cast zero-extends or truncates to the read port width.
    assign q = PWIDTH'(rd_word);

    assign lo   = rd_word[HW-1:0];
    assign hi   = rd_word[DWIDTH-1:HW];
    assign prod = DWIDTH'(lo) * DWIDTH'(hi);

    // Priority: reset, then write (clears), then in-range compute.
    always_comb begin
        mac_d = mac_q;
        if (rst) begin
            mac_d = '0;
        end else if (w_en) begin
            mac_d = '0;
        end else if (p_en && in_range) begin
            mac_d = mac_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        mac_q <= mac_d;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_en && in_range) begin
            mem[idx] <= d;
        end
    end

    assign mac_out = mac_q;

endmodule

// File: tb/tb_pim_model.sv
// Directed testbench for pim_model: a vector table against a default-parameter instance plus
// a hand-written sequence against an instance with a non-zero base and a small depth.
module tb_pim_model;

    logic        clk;
    logic        rst;
    logic [31:0] q;
    logic [31:0] mac_out;
    logic [31:0] d;
    logic [15:0] addr;
    logic        w_en;
    logic        p_en;

    // Second instance: base 16, 32 words, so addresses 16..47 are in range.
    logic        rst2;
    logic [31:0] q2;
    logic [31:0] mac_out2;
    logic [31:0] d2;
    logic [7:0]  addr2;
    logic        w_en2;
    logic        p_en2;

    int n_vec;
    int n_miss;

    pim_model dut (
        .clk     (clk),
        .rst     (rst),
        .q       (q),
        .mac_out (mac_out),
        .d       (d),
        .addr    (addr),
        .w_en    (w_en),
        .p_en    (p_en)
    );

    pim_model #(
        .PIM_ADDR_BEGIN (16),
        .DWIDTH         (32),
        .AWIDTH         (8),
        .PWIDTH         (32),
        .PDEPTH         (32)
    ) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .q       (q2),
        .mac_out (mac_out2),
        .d       (d2),
        .addr    (addr2),
        .w_en    (w_en2),
        .p_en    (p_en2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        w_en;
        logic        p_en;
        logic [15:0] addr;
        logic [31:0] d;
        logic [31:0] exp_q;   // q during the cycle, before the edge
        logic [31:0] exp_mac; // mac_out after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic r, input logic w, input logic p,
                       input logic [15:0] a, input logic [31:0] dd,
                       input logic [31:0] eq, input logic [31:0] em);
        vec_t v;
        v.name = name; v.rst = r; v.w_en = w; v.p_en = p; v.addr = a; v.d = dd;
        v.exp_q = eq; v.exp_mac = em;
        vecs.push_back(v);
    endtask

    task automatic step2(input string name, input logic r, input logic w, input logic p,
                         input logic [7:0] a, input logic [31:0] dd,
                         input logic [31:0] eq, input logic [31:0] em);
        @(negedge clk);
        rst2 = r; w_en2 = w; p_en2 = p; addr2 = a; d2 = dd;
        #1;
        check({name, ".q"}, q2, eq);
        @(posedge clk);
        #1;
        check({name, ".mac"}, mac_out2, em);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst  = 1'b1; w_en = 1'b0; p_en = 1'b1; addr = '0; d = '0;
        rst2 = 1'b1; w_en2 = 1'b0; p_en2 = 1'b0; addr2 = '0; d2 = '0;

        //   name          rst  w    p    addr    d              exp_q          exp_mac
        add("reset0",     1'b1, 1'b0, 1'b1, 16'd0, 32'h0,        32'h0,        32'h0);
        add("reset1",     1'b1, 1'b0, 1'b1, 16'd0, 32'h0,        32'h0,        32'h0);
        add("wr5",        1'b0, 1'b1, 1'b0, 16'd5, 32'hDEADBEEF, 32'h0,        32'h0);
        add("rd5",        1'b0, 1'b0, 1'b0, 16'd5, 32'h0,        32'hDEADBEEF, 32'h0);
        add("wr1",        1'b0, 1'b1, 1'b0, 16'd1, 32'h00030004, 32'h0,        32'h0);
        add("wr2",        1'b0, 1'b1, 1'b0, 16'd2, 32'h00050006, 32'h0,        32'h0);
        add("mac1",       1'b0, 1'b0, 1'b1, 16'd1, 32'h0,        32'h00030004, 32'd12);
        add("mac2",       1'b0, 1'b0, 1'b1, 16'd2, 32'h0,        32'h00050006, 32'd42);
        add("idle",       1'b0, 1'b0, 1'b0, 16'd2, 32'h0,        32'h00050006, 32'd42);
        add("wr_p7",      1'b0, 1'b1, 1'b1, 16'd7, 32'h00020002, 32'h0,        32'h0);
        add("mac7",       1'b0, 1'b0, 1'b1, 16'd7, 32'h0,        32'h00020002, 32'd4);
        add("wr3",        1'b0, 1'b1, 1'b0, 16'd3, 32'hFFFFFFFF, 32'h0,        32'h0);
        add("wrap_a",     1'b0, 1'b0, 1'b1, 16'd3, 32'h0,        32'hFFFFFFFF, 32'hFFFE0001);
        add("wrap_b",     1'b0, 1'b0, 1'b1, 16'd3, 32'h0,        32'hFFFFFFFF, 32'hFFFC0002);
        add("rst_wr5",    1'b1, 1'b1, 1'b0, 16'd5, 32'h12345678, 32'hDEADBEEF, 32'h0);
        add("rd5_kept",   1'b0, 1'b0, 1'b0, 16'd5, 32'h0,        32'hDEADBEEF, 32'h0);
        add("mac1_again", 1'b0, 1'b0, 1'b1, 16'd1, 32'h0,        32'h00030004, 32'd12);
        add("mac6_zero",  1'b0, 1'b0, 1'b1, 16'd6, 32'h0,        32'h0,        32'd12);
        add("rst_p1",     1'b1, 1'b0, 1'b1, 16'd1, 32'h0,        32'h00030004, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; w_en = vecs[i].w_en; p_en = vecs[i].p_en;
            addr = vecs[i].addr; d = vecs[i].d;
            #1;
            check({vecs[i].name, ".q"}, q, vecs[i].exp_q);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".mac"}, mac_out, vecs[i].exp_mac);
        end

        // Base/depth boundaries on the second instance.
        step2("r2_reset",  1'b1, 1'b0, 1'b0, 8'd16, 32'h0,        32'h0,        32'h0);
        step2("r2_wr4",    1'b0, 1'b1, 1'b0, 8'd4,  32'h00030004, 32'h0,        32'h0);
        step2("r2_rd4",    1'b0, 1'b0, 1'b0, 8'd4,  32'h0,        32'h0,        32'h0);
        step2("r2_rd16",   1'b0, 1'b0, 1'b0, 8'd16, 32'h0,        32'h0,        32'h0);
        step2("r2_wr20",   1'b0, 1'b1, 1'b0, 8'd20, 32'h00030004, 32'h0,        32'h0);
        step2("r2_mac20",  1'b0, 1'b0, 1'b1, 8'd20, 32'h0,        32'h00030004, 32'd12);
        step2("r2_mac4",   1'b0, 1'b0, 1'b1, 8'd4,  32'h0,        32'h0,        32'd12);
        step2("r2_mac52",  1'b0, 1'b0, 1'b1, 8'd52, 32'h0,        32'h0,        32'd12);
        // addr 52 is past the end; its truncated index would alias addr 20.
        step2("r2_wr52",   1'b0, 1'b1, 1'b0, 8'd52, 32'hFFFFFFFF, 32'h0,        32'h0);
        step2("r2_rd20",   1'b0, 1'b0, 1'b0, 8'd20, 32'h0,        32'h00030004, 32'h0);
        step2("r2_wr47",   1'b0, 1'b1, 1'b0, 8'd47, 32'h00020003, 32'h0,        32'h0);
        step2("r2_mac47",  1'b0, 1'b0, 1'b1, 8'd47, 32'h0,        32'h00020003, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pim_model.md
Name: pim_model

Overview:
- Behavioural processing-in-memory model: a word-addressed single-port memory with a built-in multiply-accumulate (MAC) engine.
- Sits behind an AXI slave wrapper that drives it each cycle with one of three operations:
  - write (w_en),
  - combinational read (q),
  - PIM compute (p_en), which accumulates a product derived from the addressed word into mac_out.

Parameters:
- PIM_ADDR_BEGIN, 0: base word address of the array; addr below this is out of range.
- DWIDTH, 32: data word width; must be even.
- AWIDTH, 16: address input width.
- PWIDTH, 32: width of the read port q.
- PDEPTH, 65536 (1<<AWIDTH): number of words in the array.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous active-high reset.
- q, output, PWIDTH: combinational read data for the addressed word.
- mac_out, output, DWIDTH: registered MAC accumulator.
- d, input, DWIDTH: write data.
- addr, input, AWIDTH: word address, shared by read, write and compute.
- w_en, input, 1: write enable.
- p_en, input, 1: PIM compute enable.

Behaviour:
- Index and range:
  - idx = addr - PIM_ADDR_BEGIN.
  - addr is in range iff addr >= PIM_ADDR_BEGIN and idx < PDEPTH.
- Storage:
  - mem[PDEPTH] of DWIDTH bits.
  - All words are 0 at time zero.
  - rst does NOT clear memory contents.
- Write:
  - On a rising edge with w_en=1 and addr in range: mem[idx] <= d, full word, no byte strobes.
  - Out-of-range writes are ignored.
- Read:
  - q = mem[idx] combinationally, with zero latency and no enable.
  - When PWIDTH > DWIDTH, q is zero-extended; when PWIDTH < DWIDTH, q is truncated to the low bits.
  - q = 0 when addr is out of range.
  - A write is visible on q from the cycle after the write edge; in the write cycle itself q shows the old content.
- Compute:
  - On a rising edge with p_en=1, w_en=0 and addr in range:
    - lo = mem[idx][DWIDTH/2-1:0]
    - hi = mem[idx][DWIDTH-1:DWIDTH/2]
    - mac_out <= mac_out + lo*hi
  - Arithmetic is unsigned: the product is DWIDTH bits and the sum wraps modulo 2^DWIDTH.
  - A p_en cycle with addr out of range leaves mac_out unchanged.
- Accumulator clear:
  - Any rising edge with w_en=1 clears mac_out to 0, regardless of addr range.
- Simultaneous w_en and p_en:
  - The write is performed and mac_out is cleared.
  - The compute is ignored.
- Idle: with w_en=0 and p_en=0, all state holds.
- Reset:
  - rst=1 at an edge forces mac_out to 0.
  - rst has priority over w_en and p_en.
  - No memory write occurs in a reset cycle.
  - q stays combinational during reset.
- No handshake; every operation completes in one cycle.
- The caller (the wrapper) guarantees at most one of write/read/compute is intended per cycle.

Test Plan:
- Reset: assert rst 2 cycles with p_en=1 -> mac_out=0; mem[0]=0 so q=0 at addr=0.
- Write/read: write d=0xDEADBEEF at addr=5, then addr=5 with w_en=0, p_en=0 -> q=0xDEADBEEF in the next cycle; in the write cycle q=0x00000000.
- MAC: write 0x00030004 to addr 1 and 0x00050006 to addr 2, then p_en at addr 1 then addr 2 -> mac_out=12, then 42.
- Wrap: write 0xFFFFFFFF to addr 3, then p_en 2 cycles at addr 3 -> mac_out = 0xFFFE0001, then 0xFFFC0002 (mod 2^32).
- Clear and simultaneous: with mac_out=42, assert w_en=1, p_en=1, addr=7, d=0x00020002 -> mac_out=0 and q at addr 7 = 0x00020002; the following p_en cycle at addr 7 -> mac_out=4.
- Range and reset priority:
  - With PIM_ADDR_BEGIN=16, a write at addr=4 is ignored and q=0.
  - rst together with w_en leaves memory unchanged and mac_out=0.
